// File: rtl/core_types_pkg.sv
// Shared core types: memory request control, register-file control and LSU state.
package core_types_pkg;
  localparam int N_BITS       = 32;
  localparam int N_BYTES      = N_BITS / 8;
  localparam int RF_IDX_WIDTH = 5;

  localparam logic [1:0] DMEM_LEN_B = 2'b00;
  localparam logic [1:0] DMEM_LEN_H = 2'b01;
  localparam logic [1:0] DMEM_LEN_W = 2'b10;

  typedef struct packed {
    logic       vld;
    logic       mtype;
    logic [1:0] len;
  } dmem_req_ctrl_t;

  typedef struct packed {
    logic [RF_IDX_WIDTH-1:0] rd;
    logic                    wr_en;
  } rf_ctrl_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RSP  = 2'b10
  } lsu_state_e;
endpackage

// File: rtl/core_lsu_load_align.sv
// Load formatter: selects the addressed byte/half/word of a read word and extends it.
module lsu_load_align
  import core_types_pkg::*;
(
  input  logic [N_BITS-1:0] rdata,
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        len,
  input  logic              is_unsigned,
  output logic [N_BITS-1:0] data
);
  logic [N_BITS-1:0] shifted;
  logic              sx;

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    sx      = 1'b0;
    data    = shifted;
    case (len)
      DMEM_LEN_B: begin
        sx   = ~is_unsigned & shifted[7];
        data = {{(N_BITS-8){sx}}, shifted[7:0]};
      end
      DMEM_LEN_H: begin
        sx   = ~is_unsigned & shifted[15];
        data = {{(N_BITS-16){sx}}, shifted[15:0]};
      end
      default: data = shifted;
    endcase
  end
endmodule

// File: rtl/core_lsu.sv
// Load/store unit: valid/ready data-memory handshake, byte lanes, load writeback.
// state | meaning
// IDLE  | waiting for an aligned request; misaligned ones are flagged and dropped
// REQ   | request presented to memory until accepted
// RSP   | load accepted, waiting for the read response
module core_lsu
  import core_types_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  dmem_req_ctrl_t          req_ctrl_i,
  input  logic                    ld_unsigned_i,
  input  logic [N_BITS-1:0]       addr_i,
  input  logic [N_BITS-1:0]       wdata_i,
  input  rf_ctrl_t                rf_ctrl_i,
  output logic                    stall_o,
  output logic                    misalign_o,
  output logic                    dmem_req_vld_o,
  input  logic                    dmem_req_rdy_i,
  output logic [N_BITS-1:0]       dmem_addr_o,
  output logic                    dmem_we_o,
  output logic [3:0]              dmem_be_o,
  output logic [N_BITS-1:0]       dmem_wdata_o,
  input  logic                    dmem_rsp_vld_i,
  input  logic [N_BITS-1:0]       dmem_rdata_i,
  output logic                    rf_wr_en_o,
  output logic [RF_IDX_WIDTH-1:0] rf_rd_o,
  output logic [N_BITS-1:0]       rf_wdata_o
);
  lsu_state_e        state;
  logic              misaligned;
  logic              accept;
  logic [3:0]        be_next;
  logic [N_BITS-1:0] wdata_next;
  logic [N_BITS-1:0] ld_data;
  logic [1:0]        len_q;
  logic [1:0]        addr_lo_q;
  logic              uns_q;
  rf_ctrl_t          rf_q;

  always_comb begin
    misaligned = ((req_ctrl_i.len == DMEM_LEN_H) && addr_i[0])
              || ((req_ctrl_i.len == DMEM_LEN_W) && (addr_i[1:0] != 2'b00))
              || (req_ctrl_i.len == 2'b11);
    accept     = (state == IDLE) && req_ctrl_i.vld && !misaligned;
    misalign_o = (state == IDLE) && req_ctrl_i.vld && misaligned;
    case (req_ctrl_i.len)
      DMEM_LEN_B: begin
        be_next    = 4'b0001 << addr_i[1:0];
        wdata_next = {N_BYTES{wdata_i[7:0]}};
      end
      DMEM_LEN_H: begin
        be_next    = 4'b0011 << addr_i[1:0];
        wdata_next = {(N_BYTES/2){wdata_i[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = wdata_i;
      end
    endcase
    stall_o = accept
           || ((state == REQ) && !(dmem_req_rdy_i && dmem_we_o))
           || ((state == RSP) && !dmem_rsp_vld_i);
    dmem_req_vld_o = (state == REQ);
  end

  lsu_load_align u_load_align (
    .rdata       (dmem_rdata_i),
    .addr_lo     (addr_lo_q),
    .len         (len_q),
    .is_unsigned (uns_q),
    .data        (ld_data)
  );

  // Request fields are formatted at capture so they sit stable on the port through REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      len_q        <= '0;
      addr_lo_q    <= '0;
      uns_q        <= 1'b0;
      rf_q         <= '0;
      dmem_addr_o  <= '0;
      dmem_we_o    <= 1'b0;
      dmem_be_o    <= '0;
      dmem_wdata_o <= '0;
      rf_wr_en_o   <= 1'b0;
      rf_rd_o      <= '0;
      rf_wdata_o   <= '0;
    end else begin
      rf_wr_en_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            len_q        <= req_ctrl_i.len;
            addr_lo_q    <= addr_i[1:0];
            uns_q        <= ld_unsigned_i;
            rf_q         <= rf_ctrl_i;
            dmem_addr_o  <= {addr_i[N_BITS-1:2], 2'b00};
            dmem_we_o    <= req_ctrl_i.mtype;
            dmem_be_o    <= be_next;
            dmem_wdata_o <= wdata_next;
            state        <= REQ;
          end
        end
        REQ: begin
          if (dmem_req_rdy_i) state <= dmem_we_o ? IDLE : RSP;
        end
        RSP: begin
          if (dmem_rsp_vld_i) begin
            rf_wr_en_o <= rf_q.wr_en && (rf_q.rd != '0);
            rf_rd_o    <= rf_q.rd;
            rf_wdata_o <= ld_data;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_core_lsu.sv
// Directed + randomized bench for core_lsu against an arithmetic reference model.
module tb_core_lsu;
  import core_types_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n;
  dmem_req_ctrl_t          req_ctrl;
  logic                    ld_unsigned;
  logic [31:0]             addr, wdata;
  rf_ctrl_t                rf_ctrl;
  logic                    stall_o, misalign_o, dmem_req_vld_o, dmem_we_o;
  logic                    dmem_req_rdy, dmem_rsp_vld;
  logic [31:0]             dmem_addr_o, dmem_wdata_o, dmem_rdata;
  logic [3:0]              dmem_be_o;
  logic                    rf_wr_en_o;
  logic [RF_IDX_WIDTH-1:0] rf_rd_o;
  logic [31:0]             rf_wdata_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  core_lsu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_ctrl_i     (req_ctrl),
    .ld_unsigned_i  (ld_unsigned),
    .addr_i         (addr),
    .wdata_i        (wdata),
    .rf_ctrl_i      (rf_ctrl),
    .stall_o        (stall_o),
    .misalign_o     (misalign_o),
    .dmem_req_vld_o (dmem_req_vld_o),
    .dmem_req_rdy_i (dmem_req_rdy),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_be_o      (dmem_be_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_rsp_vld_i (dmem_rsp_vld),
    .dmem_rdata_i   (dmem_rdata),
    .rf_wr_en_o     (rf_wr_en_o),
    .rf_rd_o        (rf_rd_o),
    .rf_wdata_o     (rf_wdata_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] len, input logic [31:0] a);
    logic [3:0] be;
    int off = (nbytes(len) == 4) ? 0 : int'(a[1:0]);
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + nbytes(len));
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] len, input logic [31:0] w);
    longint unsigned v;
    if (len == 2'b00) v = longint'(w & 32'hFF) * 64'h01010101;
    else if (len == 2'b01) v = longint'(w & 32'hFFFF) * 64'h00010001;
    else v = longint'(w);
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] len, input bit uns,
                                             input logic [31:0] a, input logic [31:0] rd_word);
    longint unsigned mask = (64'd1 << (8 * nbytes(len))) - 1;
    longint unsigned v = (longint'(rd_word) >> (8 * int'(a[1:0]))) & mask;
    longint unsigned half = (mask + 1) / 2;
    if (!uns && v >= half) v = v + (64'hFFFF_FFFF - mask);
    return v[31:0];
  endfunction

  // Starts at a negedge with the unit idle, ends at a negedge with the unit idle.
  task automatic txn(input bit st, input logic [1:0] len, input bit uns,
                     input logic [31:0] a, input logic [31:0] w,
                     input logic [4:0] rd, input bit wen,
                     input int rdy_dly, input int rsp_dly, input logic [31:0] rword);
    req_ctrl    = '{vld: 1'b1, mtype: st, len: len};
    ld_unsigned = uns;
    addr        = a;
    wdata       = w;
    rf_ctrl     = '{rd: rd, wr_en: wen};
    #1;
    chk("accept_stall", 32'(stall_o), 32'd1);
    chk("accept_misalign", 32'(misalign_o), 32'd0);
    chk("accept_req_vld", 32'(dmem_req_vld_o), 32'd0);
    @(negedge clk);
    for (int k = 0; k <= rdy_dly; k++) begin
      dmem_req_rdy = (k == rdy_dly);
      #1;
      chk("req_vld", 32'(dmem_req_vld_o), 32'd1);
      chk("req_addr", dmem_addr_o, {a[31:2], 2'b00});
      chk("req_we", 32'(dmem_we_o), 32'(st));
      chk("req_be", 32'(dmem_be_o), 32'(model_be(len, a)));
      if (st) chk("req_wdata", dmem_wdata_o, model_wdata(len, w));
      chk("req_stall", 32'(stall_o), (k == rdy_dly && st) ? 32'd0 : 32'd1);
      @(negedge clk);
    end
    dmem_req_rdy = 1'b0;
    if (st) begin
      req_ctrl.vld = 1'b0;
      #1;
      chk("st_done_req_vld", 32'(dmem_req_vld_o), 32'd0);
      chk("st_done_stall", 32'(stall_o), 32'd0);
    end else begin
      for (int j = 0; j <= rsp_dly; j++) begin
        dmem_rsp_vld = (j == rsp_dly);
        dmem_rdata   = (j == rsp_dly) ? rword : $urandom;
        #1;
        chk("rsp_req_vld", 32'(dmem_req_vld_o), 32'd0);
        chk("rsp_stall", 32'(stall_o), (j == rsp_dly) ? 32'd0 : 32'd1);
        chk("rsp_wr_en", 32'(rf_wr_en_o), 32'd0);
        @(negedge clk);
      end
      dmem_rsp_vld = 1'b0;
      dmem_rdata   = $urandom;
      req_ctrl.vld = 1'b0;
      #1;
      chk("wb_wr_en", 32'(rf_wr_en_o), 32'(wen && rd != 5'd0));
      if (wen && rd != 5'd0) begin
        chk("wb_rd", 32'(rf_rd_o), 32'(rd));
        chk("wb_wdata", rf_wdata_o, model_load(len, uns, a, rword));
      end
      @(negedge clk);
      #1;
      chk("wb_pulse_end", 32'(rf_wr_en_o), 32'd0);
      chk("wb_hold_rd_valid", 32'(dmem_req_vld_o), 32'd0);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    req_ctrl     = '0;
    ld_unsigned  = 1'b0;
    addr         = '0;
    wdata        = '0;
    rf_ctrl      = '0;
    dmem_req_rdy = 1'b0;
    dmem_rsp_vld = 1'b0;
    dmem_rdata   = '0;
    #3;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_req_vld", 32'(dmem_req_vld_o), 32'd0);
    chk("rst_be", 32'(dmem_be_o), 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    chk("rst_wr_en", 32'(rf_wr_en_o), 32'd0);
    chk("rst_wdata", rf_wdata_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // store byte at 0x1003
    txn(1'b1, DMEM_LEN_B, 1'b0, 32'h1003, 32'h0000_00AB, 5'd0, 1'b0, 0, 0, 32'h0);
    chk("sb_be_fixed", 32'(model_be(DMEM_LEN_B, 32'h1003)), 32'h8);
    // load half signed and unsigned at 0x2002
    txn(1'b0, DMEM_LEN_H, 1'b0, 32'h2002, 32'h0, 5'd5, 1'b1, 0, 0, 32'h8001_1234);
    chk("lh_value", rf_wdata_o, 32'hFFFF_8001);
    txn(1'b0, DMEM_LEN_H, 1'b1, 32'h2002, 32'h0, 5'd5, 1'b1, 0, 0, 32'h8001_1234);
    chk("lhu_value", rf_wdata_o, 32'h0000_8001);
    // back-pressure on a word store
    txn(1'b1, DMEM_LEN_W, 1'b0, 32'h4000, 32'hDEAD_BEEF, 5'd0, 1'b0, 3, 0, 32'h0);

    // misaligned word, then reserved length
    req_ctrl = '{vld: 1'b1, mtype: 1'b0, len: DMEM_LEN_W};
    addr     = 32'h2001;
    rf_ctrl  = '{rd: 5'd3, wr_en: 1'b1};
    #1;
    chk("mis_w_flag", 32'(misalign_o), 32'd1);
    chk("mis_w_stall", 32'(stall_o), 32'd0);
    chk("mis_w_req_vld", 32'(dmem_req_vld_o), 32'd0);
    @(negedge clk);
    #1;
    chk("mis_w_still_idle", 32'(dmem_req_vld_o), 32'd0);
    req_ctrl.len = 2'b11;
    addr         = 32'h2000;
    #1;
    chk("mis_len_flag", 32'(misalign_o), 32'd1);
    chk("mis_len_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    #1;
    chk("mis_len_idle", 32'(dmem_req_vld_o), 32'd0);
    req_ctrl.vld = 1'b0;
    #1;
    chk("mis_clear", 32'(misalign_o), 32'd0);
    @(negedge clk);

    // byte load to x0
    txn(1'b0, DMEM_LEN_B, 1'b0, 32'h3001, 32'h0, 5'd0, 1'b1, 1, 1, 32'h0000_7F00);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  len = 2'($urandom_range(0, 2));
      logic [31:0] a   = $urandom;
      if (len == DMEM_LEN_H) a[0] = 1'b0;
      if (len == DMEM_LEN_W) a[1:0] = 2'b00;
      txn(1'($urandom_range(0, 1)), len, 1'($urandom_range(0, 1)), a, $urandom,
          5'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom);
    end

    // reset while waiting for a load response
    req_ctrl = '{vld: 1'b1, mtype: 1'b0, len: DMEM_LEN_W};
    addr     = 32'h3000;
    rf_ctrl  = '{rd: 5'd7, wr_en: 1'b1};
    @(negedge clk);
    dmem_req_rdy = 1'b1;
    @(negedge clk);
    dmem_req_rdy = 1'b0;
    #1;
    chk("rsp_wait_stall", 32'(stall_o), 32'd1);
    req_ctrl.vld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall_o), 32'd0);
    chk("mid_rst_req_vld", 32'(dmem_req_vld_o), 32'd0);
    chk("mid_rst_addr", dmem_addr_o, 32'd0);
    chk("mid_rst_we", 32'(dmem_we_o), 32'd0);
    chk("mid_rst_be", 32'(dmem_be_o), 32'd0);
    chk("mid_rst_wdata", dmem_wdata_o, 32'd0);
    chk("mid_rst_rd", 32'(rf_rd_o), 32'd0);
    chk("mid_rst_rf_wdata", rf_wdata_o, 32'd0);
    @(negedge clk);
    rst_n        = 1'b1;
    dmem_rsp_vld = 1'b1;
    dmem_rdata   = 32'h1234_5678;
    @(negedge clk);
    dmem_rsp_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_rst_no_wb", 32'(rf_wr_en_o), 32'd0);
      chk("post_rst_req_vld", 32'(dmem_req_vld_o), 32'd0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/core_lsu.md
# core_lsu

Load/store unit for the core's memory stage. Consumes the memory-request control word produced alongside the ALU result (`dmem_req_ctrl_t`, address, store data, `rf_ctrl_t`), runs a valid/ready request and response handshake with the data-memory port, and stalls upstream while an access is in flight. It also aligns and extends load data, and drives the load register-file writeback port. Muxing against ALU writeback is outside this block.

## Interface

- `N_BITS`, default 32 (from `core_types_pkg`): data and address width.
- `clk`, input, 1: single clock.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `req_ctrl_i`, input, `dmem_req_ctrl_t`: `vld`, `mtype` (0 = read, 1 = write), and `len` (00 = byte, 01 = half, 10 = word, 11 = reserved).
- `ld_unsigned_i`, input, 1: zero-extend the load (LBU/LHU).
- `addr_i`, input, `N_BITS`: effective byte address.
- `wdata_i`, input, `N_BITS`: store data, right-justified.
- `rf_ctrl_i`, input, `rf_ctrl_t`: load destination register and write enable.
- `stall_o`, output, 1: upstream holds all inputs stable while high.
- `misalign_o`, output, 1: misaligned or reserved-length request rejected this cycle.
- `dmem_req_vld_o`, output, 1: memory request valid.
- `dmem_req_rdy_i`, input, 1: memory accepts the request.
- `dmem_addr_o`, output, `N_BITS`: word-aligned address, `addr[1:0]` = 0.
- `dmem_we_o`, output, 1: write request.
- `dmem_be_o`, output, 4: byte enables.
- `dmem_wdata_o`, output, `N_BITS`: lane-replicated store data.
- `dmem_rsp_vld_i`, input, 1: read response valid.
- `dmem_rdata_i`, input, `N_BITS`: read word.
- `rf_wr_en_o`, output, 1: load writeback enable.
- `rf_rd_o`, output, `RF_IDX_WIDTH`: load destination register.
- `rf_wdata_o`, output, `N_BITS`: aligned and extended load data.

## Operation

- **FSM states:** IDLE, REQ, RSP.
- **Misalignment check:** a request is misaligned if any of these hold:
  - `len` = 01 and `addr[0]` = 1
  - `len` = 10 and `addr[1:0]` != 0
  - `len` = 11
- **IDLE:** when `vld` is high and the request is aligned, capture `mtype`, `len`, `ld_unsigned`, `addr`, `wdata` and `rf_ctrl`, then go to REQ.
- **IDLE, misaligned:** `misalign_o` is high combinationally, no request is issued, no stall, and the state stays IDLE.
- **REQ:** `dmem_req_vld_o` = 1 and the request fields come from the captured registers.
  - If `dmem_req_rdy_i` is high and the access is a store, go to IDLE.
  - If `dmem_req_rdy_i` is high and the access is a load, go to RSP.
- **RSP:** wait for `dmem_rsp_vld_i`. On the response, register the writeback and go to IDLE.
  - `dmem_rsp_vld_i` is ignored in IDLE and REQ. Memory never returns a response in the acceptance cycle.
- **Byte enables:**
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << addr[1:0]`
  - word: `4'b1111`
- **Store data:** byte is `{4{wdata[7:0]}}`, half is `{2{wdata[15:0]}}`, word passes through.
- **Load formatting:**
  - Shift `rdata` right by `8*addr[1:0]`.
  - Take 8, 16 or 32 bits according to `len`.
  - Sign-extend, or zero-extend when `ld_unsigned` is set.
- **Writeback:**
  - `rf_wr_en_o` = captured `wr_en` AND `rd` != 0.
  - It is a one-cycle pulse in the cycle after the response.
  - `rf_rd_o` and `rf_wdata_o` are held until the next writeback.
- **Stall:** `stall_o` is the OR of:
  - (IDLE & `vld` & aligned)
  - (REQ & !(`rdy` & store))
  - (RSP & !`rsp_vld`)

## Timing

- **Reset values:** every output is 0 and the state is IDLE. Reset is asynchronous, so `dmem_req_vld_o` drops as soon as `rst_n` falls.
- **Reset mid-operation:** the transaction is discarded with no writeback. The memory side is reset by the same `rst_n`.
- **Store latency:** `stall_o` is high in cycle 0 (accept). With `rdy` high in cycle 1, `stall_o` is low in cycle 1 and the unit is IDLE in cycle 2. Minimum occupancy is 2 cycles.
- **Load latency:**
  - Request issued in cycle 1, response in cycle 2 at the earliest.
  - `stall_o` is low in cycle 2.
  - `rf_wr_en_o` pulses in cycle 3.
  - Minimum occupancy is 3 cycles.
- **Request stability:** `dmem_req_vld_o` stays high with all fields stable until `rdy`. The request is never withdrawn.
- **Back-to-back requests:** a new request is accepted in the cycle the unit returns to IDLE.

## Structure

- **Add to `core_types_pkg`:**
  - `lsu_state_e` (IDLE, REQ, RSP).
  - Localparams `DMEM_LEN_B`, `DMEM_LEN_H`, `DMEM_LEN_W`.
  - `N_BYTES = N_BITS/8`.
- **Sub-module:** `lsu_load_align`, a combinational formatter. Inputs are `rdata`, `addr[1:0]`, `len` and `unsigned`. Output is the extended word. The byte-enable and lane-replication logic stays in `core_lsu`.

## Test plan

- **Store byte.** `addr` 0x1003, `wdata` 0xAB, `rdy` high the first REQ cycle. Expect `be` 1000, `wdata` 0xABABABAB, `dmem_addr` 0x1000, `stall_o` high for 1 cycle.
- **Load half signed.** `addr` 0x2002, `rdata` 0x8001_1234, `rd` = 5. Expect `rf_wdata` 0xFFFF8001, `rf_rd` 5, `rf_wr_en` high for one cycle. Repeat with `ld_unsigned`: expect 0x00008001.
- **Back-pressure.** `rdy` held low for 3 cycles on a word store. Expect `dmem_req_vld_o` and all fields stable and `stall_o` high for 4 cycles.
- **Misalignment.** Word load at 0x2001, then `len` = 11. Expect `misalign_o` high, `dmem_req_vld_o` low, `stall_o` low, state remains IDLE.
- **`rd` = x0.** Load byte to x0, `rdata` 0x7F. Expect the access to complete and `rf_wr_en_o` to stay 0.
- **Reset in RSP.** Deassert `rst_n` while waiting for a response. Expect all outputs 0 immediately and no writeback after release.
